control_movimiento_seq: RTL and testbench

Parametrised two-axis solar-tracker motion sequencer, the successor to the unclocked photoresistor comparator. It drives the theta (vertical) and phi (horizontal) motor direction codes in one of two modes:
- Automatic: photoresistor balancing.
- Manual: shortest-path angle seek with wrap-around.

It adds the following, and sits between the ADC/UART data registers and the motor drivers:
- Registered outputs and tolerance hysteresis.
- Settle debounce and a per-axis move timeout with fault latch.
- Alignment pulses.

---
 rtl/control_movimiento_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_control_movimiento_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/control_movimiento_seq.sv
// ---------------------------------------------------------------------------
// control_movimiento_seq
//
// Two-axis solar-tracker motion sequencer. It drives the theta (vertical) and
// phi (horizontal) motor direction codes. Axes are moved one at a time: theta
// first, then phi.
//   - Automatic mode balances pairs of photoresistors.
//   - Manual mode seeks target angles along the shortest path, with
//     wrap-around at ANGLE_MAX.
// Every output is registered, so a direction decision shows up one cycle
// after its inputs are sampled.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   s[1:0]                     mode: 00 automatic, 01 manual, 1x hold
//   R_vertical_1/2             vertical photoresistor pair   (automatic)
//   R_horizontal_1/2           horizontal photoresistor pair (automatic)
//   theta_manual/theta_actual  theta target / measurement    (manual)
//   phi_manual/phi_actual      phi target / measurement      (manual)
//   s_out_theta, s_out_phi     motor codes: 00 stop, 01 increase, 11 decrease
//   busy                       high while an axis is being moved
//   aligned                    one-cycle pulse when a full pass completes
//   fault                      latched move timeout
//   dbg_state_o                current FSM state (0 idle, 1 theta, 2 phi, 3 fault)
// ---------------------------------------------------------------------------
module control_movimiento_seq #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned TOL          = 5,
    parameter int unsigned SETTLE_CYC   = 8,
    parameter int unsigned MOVE_TIMEOUT = 4096,
    parameter int unsigned REARM_CYC    = 64,
    parameter int unsigned ANGLE_MAX    = 360
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        s,
    input  logic [DATA_W-1:0] R_vertical_1,
    input  logic [DATA_W-1:0] R_vertical_2,
    input  logic [DATA_W-1:0] R_horizontal_1,
    input  logic [DATA_W-1:0] R_horizontal_2,
    input  logic [DATA_W-1:0] theta_manual,
    input  logic [DATA_W-1:0] theta_actual,
    input  logic [DATA_W-1:0] phi_manual,
    input  logic [DATA_W-1:0] phi_actual,
    output logic [1:0]        s_out_theta,
    output logic [1:0]        s_out_phi,
    output logic              busy,
    output logic              aligned,
    output logic              fault,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_THETA = 2'd1,
        S_PHI   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int unsigned AW = DATA_W + 1;
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned MW = $clog2(MOVE_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(REARM_CYC + 1);

    localparam logic [AW-1:0] TOL_W  = AW'(TOL);
    localparam logic [AW-1:0] AMAX_W = AW'(ANGLE_MAX);
    localparam logic [AW-1:0] HALF_W = AW'(ANGLE_MAX / 2);

    // Returns {balanced, direction code} for one axis in the given mode.
    // Every difference is taken one bit wider than the inputs, so neither
    // |R1-R2| nor the modular angle difference can wrap.
    function automatic logic [2:0] eval_axis(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] r1,
        input logic [DATA_W-1:0] r2,
        input logic [DATA_W-1:0] tgt,
        input logic [DATA_W-1:0] act
    );
        logic [AW-1:0] a1, a2, t, c, diff, d;
        logic          bal;
        logic [1:0]    code;
        a1   = {1'b0, r1};
        a2   = {1'b0, r2};
        t    = {1'b0, tgt};
        c    = {1'b0, act};
        diff = '0;
        d    = '0;
        bal  = 1'b1;
        code = 2'b00;
        case (mode)
            2'b00: begin
                diff = (a1 >= a2) ? (a1 - a2) : (a2 - a1);
                bal  = (diff <= TOL_W);
                code = (a1 > a2) ? 2'b01 : 2'b11;
            end
            2'b01: begin
                // Angles that are out of range leave the axis undriven.
                if (t < AMAX_W && c < AMAX_W) begin
                    d    = (t >= c) ? (t - c) : (t + AMAX_W - c);
                    bal  = (d <= TOL_W) || ((AMAX_W - d) <= TOL_W);
                    // The exact half-turn tie resolves to the increasing direction.
                    code = (d <= HALF_W) ? 2'b01 : 2'b11;
                end
            end
            default: begin
                bal = 1'b1;
            end
        endcase
        if (bal) begin
            code = 2'b00;
        end
        return {bal, code};
    endfunction

    logic [2:0] th_eval, ph_eval;
    logic       th_bal, ph_bal;
    logic [1:0] th_code, ph_code;

    assign th_eval = eval_axis(s, R_vertical_1, R_vertical_2, theta_manual, theta_actual);
    assign ph_eval = eval_axis(s, R_horizontal_1, R_horizontal_2, phi_manual, phi_actual);
    assign th_bal  = th_eval[2];
    assign th_code = th_eval[1:0];
    assign ph_bal  = ph_eval[2];
    assign ph_code = ph_eval[1:0];

    state_t        state_q;
    logic [1:0]    s_q;
    logic          s_vld_q;      // s_q holds a real sample (not the reset value)
    logic          rearm_imm_q;  // next automatic pass starts without waiting
    logic [SW-1:0] settle_q;
    logic [MW-1:0] move_q;
    logic [RW-1:0] rearm_q;
    logic [1:0]    theta_q, phi_q;
    logic          busy_q, aligned_q, fault_q;
    logic          mode_chg;

    // The first edge after reset only captures the mode; it is not a change.
    assign mode_chg = s_vld_q && (s != s_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            s_q         <= 2'b00;
            s_vld_q     <= 1'b0;
            rearm_imm_q <= 1'b1;
            settle_q    <= '0;
            move_q      <= '0;
            rearm_q     <= '0;
            theta_q     <= 2'b00;
            phi_q       <= 2'b00;
            busy_q      <= 1'b0;
            aligned_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            s_q       <= s;
            s_vld_q   <= 1'b1;
            aligned_q <= 1'b0;
            if (mode_chg) begin
                state_q     <= S_IDLE;
                rearm_imm_q <= 1'b1;
                settle_q    <= '0;
                move_q      <= '0;
                rearm_q     <= '0;
                theta_q     <= 2'b00;
                phi_q       <= 2'b00;
                busy_q      <= 1'b0;
                fault_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        theta_q <= 2'b00;
                        phi_q   <= 2'b00;
                        fault_q <= 1'b0;
                        if (s == 2'b00) begin
                            if (rearm_imm_q || rearm_q == RW'(REARM_CYC - 1)) begin
                                state_q     <= S_THETA;
                                busy_q      <= 1'b1;
                                rearm_imm_q <= 1'b0;
                                rearm_q     <= '0;
                                settle_q    <= '0;
                                move_q      <= '0;
                            end else begin
                                rearm_q <= rearm_q + RW'(1);
                            end
                        end else if (s == 2'b01 && (!th_bal || !ph_bal)) begin
                            state_q  <= S_THETA;
                            busy_q   <= 1'b1;
                            settle_q <= '0;
                            move_q   <= '0;
                        end
                    end
                    S_THETA: begin
                        phi_q <= 2'b00;
                        if (s[1]) begin
                            state_q <= S_IDLE;
                            theta_q <= 2'b00;
                            busy_q  <= 1'b0;
                        end else if (move_q == MW'(MOVE_TIMEOUT - 1)) begin
                            state_q <= S_FAULT;
                            theta_q <= 2'b00;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            move_q <= move_q + MW'(1);
                            if (th_bal) begin
                                theta_q <= 2'b00;
                                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                                    state_q  <= S_PHI;
                                    settle_q <= '0;
                                    move_q   <= '0;
                                end else begin
                                    settle_q <= settle_q + SW'(1);
                                end
                            end else begin
                                settle_q <= '0;
                                theta_q  <= th_code;
                            end
                        end
                    end
                    S_PHI: begin
                        theta_q <= 2'b00;
                        if (s[1]) begin
                            state_q <= S_IDLE;
                            phi_q   <= 2'b00;
                            busy_q  <= 1'b0;
                        end else if (move_q == MW'(MOVE_TIMEOUT - 1)) begin
                            state_q <= S_FAULT;
                            phi_q   <= 2'b00;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            move_q <= move_q + MW'(1);
                            if (ph_bal) begin
                                phi_q <= 2'b00;
                                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                                    state_q   <= S_IDLE;
                                    settle_q  <= '0;
                                    move_q    <= '0;
                                    rearm_q   <= '0;
                                    busy_q    <= 1'b0;
                                    aligned_q <= 1'b1;
                                end else begin
                                    settle_q <= settle_q + SW'(1);
                                end
                            end else begin
                                settle_q <= '0;
                                phi_q    <= ph_code;
                            end
                        end
                    end
                    default: begin
                        // S_FAULT: motors stay stopped until hold mode is selected.
                        theta_q <= 2'b00;
                        phi_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        if (s[1]) begin
                            state_q <= S_IDLE;
                            fault_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign s_out_theta = theta_q;
    assign s_out_phi   = phi_q;
    assign busy        = busy_q;
    assign aligned     = aligned_q;
    assign fault       = fault_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_control_movimiento_seq.sv
// ---------------------------------------------------------------------------
// tb_control_movimiento_seq
//
// Bench for control_movimiento_seq with small parameters (TOL=5, SETTLE_CYC=4,
// MOVE_TIMEOUT=20, REARM_CYC=8, ANGLE_MAX=360).
//   - A table of single-axis direction vectors is applied from reset; each
//     expectation goes into exp_q when the vector is driven and is compared
//     once the decision is visible.
//   - Hand-written sequences cover the multi-cycle behaviour: a full
//     automatic pass, the move timeout, a mode switch during settle, and an
//     asynchronous reset while a motor is moving.
// ---------------------------------------------------------------------------
module tb_control_movimiento_seq;

    localparam int unsigned DW           = 16;
    localparam int unsigned SETTLE_CYC   = 4;
    localparam int unsigned MOVE_TIMEOUT = 20;
    localparam int unsigned REARM_CYC    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    s;
    logic [DW-1:0] rv1, rv2, rh1, rh2, tm, ta, pm, pa;
    logic [1:0]    s_out_theta, s_out_phi, dbg_state;
    logic          busy, aligned, fault;

    control_movimiento_seq #(
        .DATA_W(DW), .TOL(5), .SETTLE_CYC(SETTLE_CYC), .MOVE_TIMEOUT(MOVE_TIMEOUT),
        .REARM_CYC(REARM_CYC), .ANGLE_MAX(360)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s(s),
        .R_vertical_1(rv1), .R_vertical_2(rv2),
        .R_horizontal_1(rh1), .R_horizontal_2(rh2),
        .theta_manual(tm), .theta_actual(ta),
        .phi_manual(pm), .phi_actual(pa),
        .s_out_theta(s_out_theta), .s_out_phi(s_out_phi),
        .busy(busy), .aligned(aligned), .fault(fault),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] a;     // R1 (automatic) or target (manual)
        logic [DW-1:0] b;     // R2 (automatic) or actual (manual)
        logic [1:0]    code;  // expected theta code
        logic          busy;  // expected busy
    } vec_t;

    localparam int NV = 18;
    vec_t          vecs[NV];
    logic [4:0]    exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        rst_n = 1'b0;
        s = 2'b10;
        rv1 = '0; rv2 = '0; rh1 = '0; rh2 = '0;
        tm = '0; ta = '0; pm = '0; pa = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] got, exp;

        vecs[0]  = '{2'b00, 16'd1000,  16'd900,   2'b01, 1'b1};
        vecs[1]  = '{2'b00, 16'd900,   16'd1000,  2'b11, 1'b1};
        vecs[2]  = '{2'b00, 16'd0,     16'd5,     2'b00, 1'b1};
        vecs[3]  = '{2'b00, 16'd0,     16'd6,     2'b11, 1'b1};
        vecs[4]  = '{2'b00, 16'd6,     16'd0,     2'b01, 1'b1};
        vecs[5]  = '{2'b00, 16'd0,     16'hFFFF,  2'b11, 1'b1};
        vecs[6]  = '{2'b00, 16'hFFFF,  16'd0,     2'b01, 1'b1};
        vecs[7]  = '{2'b00, 16'd5,     16'd0,     2'b00, 1'b1};
        vecs[8]  = '{2'b01, 16'd10,    16'd350,   2'b01, 1'b1};
        vecs[9]  = '{2'b01, 16'd350,   16'd10,    2'b11, 1'b1};
        vecs[10] = '{2'b01, 16'd180,   16'd0,     2'b01, 1'b1};
        vecs[11] = '{2'b01, 16'd104,   16'd100,   2'b00, 1'b0};
        vecs[12] = '{2'b01, 16'd0,     16'd180,   2'b01, 1'b1};
        vecs[13] = '{2'b01, 16'd181,   16'd0,     2'b11, 1'b1};
        vecs[14] = '{2'b01, 16'd400,   16'd0,     2'b00, 1'b0};
        vecs[15] = '{2'b01, 16'd0,     16'd355,   2'b00, 1'b0};
        vecs[16] = '{2'b01, 16'd0,     16'd354,   2'b01, 1'b1};
        vecs[17] = '{2'b01, 16'd354,   16'd0,     2'b11, 1'b1};

        // Reset state.
        start_reset();
        check("reset_outputs", {9'd0, s_out_theta, s_out_phi, busy, aligned, fault},
              16'd0);
        check("reset_state", dbg_state, 2'd0);

        // Direction table: from reset the first edge enters S_THETA (automatic)
        // or stays idle (balanced manual); the decision shows after edge 2.
        for (int i = 0; i < NV; i++) begin
            start_reset();
            s = vecs[i].mode;
            if (vecs[i].mode == 2'b00) begin
                rv1 = vecs[i].a;
                rv2 = vecs[i].b;
            end else begin
                tm = vecs[i].a;
                ta = vecs[i].b;
            end
            exp_q.push_back({vecs[i].busy, vecs[i].code, 2'b00});
            release_reset();
            tick();
            tick();
            got = {busy, s_out_theta, s_out_phi};
            exp = exp_q.pop_front();
            check($sformatf("vec%0d", i), {11'd0, got}, {11'd0, exp});
        end
        check("scoreboard_empty", exp_q.size(), 16'd0);

        // Automatic pass: theta moves then settles, phi moves then settles.
        start_reset();
        s = 2'b00; rv1 = 16'd1000; rv2 = 16'd900; rh1 = 16'd500; rh2 = 16'd700;
        release_reset();
        tick();
        check("auto_enter_busy", busy, 16'd1);
        check("auto_enter_theta", s_out_theta, 16'd0);
        tick();
        check("auto_theta_cw", s_out_theta, 16'b01);
        check("auto_phi_forced", s_out_phi, 16'd0);
        rv1 = 16'd902;
        for (int k = 0; k < SETTLE_CYC - 1; k++) begin
            tick();
            check("auto_theta_settle", {dbg_state, s_out_theta}, {12'd0, 2'd1, 2'b00});
        end
        tick();
        check("auto_to_phi", dbg_state, 16'd2);
        tick();
        check("auto_phi_ccw", {s_out_theta, s_out_phi}, 16'b0011);
        rh2 = 16'd500;
        for (int k = 0; k < SETTLE_CYC - 1; k++) begin
            tick();
            check("auto_phi_settle_no_pulse", aligned, 16'd0);
        end
        tick();
        check("auto_aligned_pulse", {aligned, busy}, 16'b10);
        tick();
        check("auto_aligned_single", aligned, 16'd0);
        repeat (REARM_CYC - 2) tick();
        check("auto_rearm_wait", busy, 16'd0);
        tick();
        check("auto_rearm_go", busy, 16'd1);

        // Timeout in S_THETA.
        start_reset();
        s = 2'b00; rv1 = 16'd1000; rv2 = 16'd0;
        release_reset();
        tick();
        for (int k = 0; k < MOVE_TIMEOUT - 1; k++) tick();
        check("tmo_before", {fault, s_out_theta}, 16'b001);
        tick();
        check("tmo_fault", {fault, busy, s_out_theta, s_out_phi}, 16'b100000);
        repeat (3) tick();
        check("tmo_latched", {fault, dbg_state}, 16'b111);
        s = 2'b10;
        tick();
        check("tmo_hold_clears", {fault, dbg_state}, 16'b000);
        tick();
        s = 2'b00;
        tick();
        check("tmo_modechg_idle", busy, 16'd0);
        tick();
        check("tmo_restart_busy", busy, 16'd1);
        tick();
        check("tmo_restart_drive", s_out_theta, 16'b01);

        // Mode switch during theta settle.
        start_reset();
        s = 2'b00; rv1 = 16'd1000; rv2 = 16'd900; tm = 16'd10; ta = 16'd350;
        release_reset();
        tick();
        tick();
        rv1 = 16'd902;
        tick();
        tick();
        check("msw_settling", {busy, s_out_theta}, 16'b100);
        s = 2'b01;
        tick();
        check("msw_idle", {dbg_state, busy, s_out_theta}, 16'd0);
        tick();
        check("msw_manual_enter", {dbg_state, busy}, 16'b011);
        tick();
        check("msw_manual_cw", s_out_theta, 16'b01);

        // Asynchronous reset while theta is being driven.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {9'd0, s_out_theta, s_out_phi, busy, aligned, fault}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
